// File: rtl/bit_pattern_detector_pkg.sv
// Shared limits, window-state typedefs and the match popcount helper for bit_pattern_detector.
package bit_pattern_detector_pkg;

  localparam int DATA_W_MAX  = 64;
  localparam int PAT_LEN_MAX = 32;
  localparam int FILL_W      = 6;
  localparam int POP_W       = 7;

  typedef logic [FILL_W-1:0]        fill_t;
  typedef logic [PAT_LEN_MAX-2:0]   hist_max_t;
  typedef logic [POP_W-1:0]         pop_t;

  function automatic pop_t popcount(input logic [DATA_W_MAX-1:0] v);
    pop_t n;
    n = '0;
    for (int i = 0; i < DATA_W_MAX; i++) begin
      n += pop_t'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/bpd_match_lane.sv
// Combinational per-beat unroll: walks inp[0]..inp[DATA_W-1] through the pattern window and
// returns the match vector plus the history/fill state left after the last bit.
module bpd_match_lane
  import bit_pattern_detector_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PAT_LEN = 4,
  parameter int HIST_W  = (PAT_LEN > 1) ? PAT_LEN - 1 : 1
) (
  input  logic [HIST_W-1:0]  hist,
  input  fill_t              fill,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  input  logic [DATA_W-1:0]  inp,
  output logic [DATA_W-1:0]  match,
  output logic [HIST_W-1:0]  hist_next,
  output fill_t              fill_next
);

  localparam fill_t FILL_FULL = fill_t'(PAT_LEN - 1);

  logic [DATA_W:0][HIST_W-1:0] hist_chain;
  logic [DATA_W:0][FILL_W-1:0] fill_chain;

  assign hist_chain[0] = hist;
  assign fill_chain[0] = fill;

  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bit
      logic [PAT_LEN-1:0] window;
      logic               full;
      logic               hit;

      // Window bit 0 is the bit being examined; older bits come from the history.
      if (PAT_LEN == 1) begin : g_one
        assign window = inp[gi];
      end else begin : g_many
        assign window = {hist_chain[gi], inp[gi]};
      end

      if (HIST_W == 1) begin : g_h1
        assign hist_chain[gi+1] = inp[gi];
      end else begin : g_hn
        assign hist_chain[gi+1] = {hist_chain[gi][HIST_W-2:0], inp[gi]};
      end

      assign full     = (fill_chain[gi] == FILL_FULL);
      assign hit      = full && (window == pattern);
      assign match[gi] = hit;
      assign fill_chain[gi+1] = (hit && !overlap) ? '0 :
                                full              ? fill_chain[gi] :
                                                    fill_chain[gi] + fill_t'(1);
    end
  endgenerate

  assign hist_next = hist_chain[DATA_W];
  assign fill_next = fill_chain[DATA_W];

endmodule

// File: rtl/bit_pattern_detector.sv
// Streaming serial-pattern detector with a one-beat registered output stage.
// Define MATCH_COUNT_EN to add the saturating per-packet match counter and the o_count port.
module bit_pattern_detector
  import bit_pattern_detector_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int PAT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [PAT_LEN-1:0] cfg_pattern,
  input  logic               cfg_overlap,
  input  logic               i_valid,
  output logic               i_ready,
  input  logic               i_sop,
  input  logic               i_eop,
  input  logic [DATA_W-1:0]  inp,
  output logic               o_valid,
  input  logic               o_ready,
  output logic               o_sop,
  output logic               o_eop,
  output logic [DATA_W-1:0]  outp
`ifdef MATCH_COUNT_EN
  ,
  output logic [CNT_W-1:0]   o_count
`endif
);

  localparam int HIST_W = (PAT_LEN > 1) ? PAT_LEN - 1 : 1;

  logic               accept;
  logic [HIST_W-1:0]  hist_reg, hist_in, hist_next;
  fill_t              fill_reg, fill_in, fill_next;
  logic [PAT_LEN-1:0] pattern_reg, pattern_in;
  logic               overlap_reg, overlap_in;
  logic [DATA_W-1:0]  match;

  assign i_ready = o_ready || !o_valid;
  assign accept  = i_valid && i_ready;

  // A sop beat starts from an empty window and already uses the config it carries.
  assign hist_in    = i_sop ? '0 : hist_reg;
  assign fill_in    = i_sop ? '0 : fill_reg;
  assign pattern_in = i_sop ? cfg_pattern : pattern_reg;
  assign overlap_in = i_sop ? cfg_overlap : overlap_reg;

  bpd_match_lane #(
    .DATA_W  (DATA_W),
    .PAT_LEN (PAT_LEN),
    .HIST_W  (HIST_W)
  ) u_lane (
    .hist      (hist_in),
    .fill      (fill_in),
    .pattern   (pattern_in),
    .overlap   (overlap_in),
    .inp       (inp),
    .match     (match),
    .hist_next (hist_next),
    .fill_next (fill_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_reg    <= '0;
      fill_reg    <= '0;
      pattern_reg <= '0;
      overlap_reg <= 1'b0;
      o_valid     <= 1'b0;
      o_sop       <= 1'b0;
      o_eop       <= 1'b0;
      outp        <= '0;
    end else if (accept) begin
      // Clearing on eop guarantees no match ever spans two packets.
      hist_reg <= i_eop ? '0 : hist_next;
      fill_reg <= i_eop ? '0 : fill_next;
      if (i_sop) begin
        pattern_reg <= cfg_pattern;
        overlap_reg <= cfg_overlap;
      end
      o_valid <= 1'b1;
      o_sop   <= i_sop;
      o_eop   <= i_eop;
      outp    <= match;
    end else if (o_valid && o_ready) begin
      o_valid <= 1'b0;
    end
  end

`ifdef MATCH_COUNT_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]       count_reg, count_base, count_sum;
  logic [CNT_W+POP_W-1:0] count_wide;

  assign count_base = i_sop ? '0 : count_reg;
  assign count_wide = {{POP_W{1'b0}}, count_base} + {{CNT_W{1'b0}}, popcount(DATA_W_MAX'(match))};
  assign count_sum  = (count_wide > {{POP_W{1'b0}}, CNT_MAX}) ? CNT_MAX : count_wide[CNT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      o_count   <= '0;
    end else if (accept) begin
      count_reg <= i_eop ? '0 : count_sum;
      o_count   <= i_eop ? count_sum : '0;
    end
  end
`endif

endmodule
